// File: rtl/shift_add_mult.sv
// shift_add_mult: parametrised sequential shift-add multiplier.
// X (sign/carry), A (accumulator) and B (multiplier) form one shift chain.
// One Start yields a full 2*WIDTH product after 2*WIDTH cycles. Signed mode
// uses two's complement, and the last partial product is subtracted because
// the multiplier MSB carries negative weight.
module shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed_Mode,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 X_Out
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ADD   = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic             x_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             mode_q;
    logic [CW-1:0]    count_q;

    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   s_ext;
    logic [WIDTH:0]   sum;
    logic             last_step;

    // Extend the operands to WIDTH+1 bits and form the add/subtract result.
    // X always equals A's MSB when ADD is entered, so extending A from its own MSB is exact.
    always_comb begin
        last_step = (count_q == LAST);
        a_ext     = mode_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
        s_ext     = mode_q ? {s_q[WIDTH-1], s_q} : {1'b0, s_q};
        sum       = (mode_q && last_step) ? (a_ext - s_ext) : (a_ext + s_ext);
    end

    // Control FSM and X/A/B datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            mode_q  <= 1'b0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        x_q     <= 1'b0;
                        a_q     <= '0;
                        b_q     <= Multiplier;
                        s_q     <= Multiplicand;
                        mode_q  <= Signed_Mode;
                        count_q <= '0;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    if (b_q[0]) begin
                        {x_q, a_q} <= sum;
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    b_q <= {a_q[0], b_q[WIDTH-1:1]};
                    a_q <= {x_q, a_q[WIDTH-1:1]};
                    if (!mode_q) begin
                        x_q <= 1'b0;
                    end
                    if (last_step) begin
                        state <= DONE;
                    end else begin
                        count_q <= count_q + 1'b1;
                        state   <= ADD;
                    end
                end
                DONE: begin
                    if (!Start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy    = (state == ADD) || (state == SHIFT);
    assign Done    = (state == DONE);
    assign Product = {a_q, b_q};
    assign X_Out   = x_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult at WIDTH 8, 16 and 2.
module tb_shift_add_mult;

    typedef struct {
        logic [31:0] prod;
        int unsigned edge_k;
    } sb_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // WIDTH = 8
    logic        st8 = 0, sm8 = 0, busy8, done8, x8;
    logic [7:0]  mc8 = 0, mp8 = 0;
    logic [15:0] prod8;
    // WIDTH = 16
    logic        st16 = 0, sm16 = 0, busy16, done16, x16;
    logic [15:0] mc16 = 0, mp16 = 0;
    logic [31:0] prod16;
    // WIDTH = 2
    logic        st2 = 0, sm2 = 0, busy2, done2, x2;
    logic [1:0]  mc2 = 0, mp2 = 0;
    logic [3:0]  prod2;

    shift_add_mult #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .Start(st8), .Signed_Mode(sm8),
        .Multiplicand(mc8), .Multiplier(mp8),
        .Busy(busy8), .Done(done8), .Product(prod8), .X_Out(x8)
    );
    shift_add_mult #(.WIDTH(16)) dut16 (
        .Clk(Clk), .Reset(Reset), .Start(st16), .Signed_Mode(sm16),
        .Multiplicand(mc16), .Multiplier(mp16),
        .Busy(busy16), .Done(done16), .Product(prod16), .X_Out(x16)
    );
    shift_add_mult #(.WIDTH(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .Start(st2), .Signed_Mode(sm2),
        .Multiplicand(mc2), .Multiplier(mp2),
        .Busy(busy2), .Done(done2), .Product(prod2), .X_Out(x2)
    );

    sb_t q8[$];
    sb_t q16[$];
    sb_t q2[$];
    int  ep8 = 0, ep16 = 0, ep2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: on each rising Done, pop the oldest expectation and compare.
    logic d8_q = 0, d16_q = 0, d2_q = 0;
    sb_t  e8, e16, e2;

    always @(negedge Clk) begin
        if (!Reset && done8 && !d8_q) begin
            ep8++;
            if (q8.size() == 0) begin
                check("w8_unexpected_done", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("w8_product", 32'(prod8), e8.prod);
                check("w8_latency", cyc - e8.edge_k, 32'd16);
            end
        end
        d8_q = done8;
    end

    always @(negedge Clk) begin
        if (!Reset && done16 && !d16_q) begin
            ep16++;
            if (q16.size() == 0) begin
                check("w16_unexpected_done", 32'd1, 32'd0);
            end else begin
                e16 = q16.pop_front();
                check("w16_product", prod16, e16.prod);
                check("w16_latency", cyc - e16.edge_k, 32'd32);
            end
        end
        d16_q = done16;
    end

    always @(negedge Clk) begin
        if (!Reset && done2 && !d2_q) begin
            ep2++;
            if (q2.size() == 0) begin
                check("w2_unexpected_done", 32'd1, 32'd0);
            end else begin
                e2 = q2.pop_front();
                check("w2_product", 32'(prod2), e2.prod);
                check("w2_latency", cyc - e2.edge_k, 32'd4);
            end
        end
        d2_q = done2;
    end

    function automatic int ep_of(input int w);
        case (w)
            8:       return ep8;
            16:      return ep16;
            default: return ep2;
        endcase
    endfunction

    function automatic logic [31:0] prod_of(input int w);
        case (w)
            8:       return 32'(prod8);
            16:      return prod16;
            default: return 32'(prod2);
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            8:       return busy8;
            16:      return busy16;
            default: return busy2;
        endcase
    endfunction

    function automatic logic done_of(input int w);
        case (w)
            8:       return done8;
            16:      return done16;
            default: return done2;
        endcase
    endfunction

    // Pulse Start for one edge, push the expectation, then scramble operands.
    task automatic issue(input int w, input logic sm, input logic [15:0] s, input logic [15:0] m,
                         input logic [31:0] exp, input bit push);
        @(negedge Clk);
        case (w)
            8:       begin sm8 = sm;  mc8 = s[7:0]; mp8 = m[7:0]; st8 = 1'b1; end
            16:      begin sm16 = sm; mc16 = s;     mp16 = m;     st16 = 1'b1; end
            default: begin sm2 = sm;  mc2 = s[1:0]; mp2 = m[1:0]; st2 = 1'b1; end
        endcase
        @(posedge Clk);
        #1;
        if (push) begin
            case (w)
                8:       q8.push_back(sb_t'{exp, cyc});
                16:      q16.push_back(sb_t'{exp, cyc});
                default: q2.push_back(sb_t'{exp, cyc});
            endcase
        end
        case (w)
            8:       begin st8 = 1'b0; sm8 = ~sm; mc8 = 8'($urandom); mp8 = 8'($urandom); end
            16:      begin st16 = 1'b0; sm16 = ~sm; mc16 = 16'($urandom); mp16 = 16'($urandom); end
            default: begin st2 = 1'b0; sm2 = ~sm; mc2 = 2'($urandom); mp2 = 2'($urandom); end
        endcase
    endtask

    task automatic wait_done(input int w, input int target);
        int n;
        n = 0;
        while (ep_of(w) < target && n < 200) begin
            @(negedge Clk);
            #1;
            n++;
        end
        if (ep_of(w) < target) begin
            check("done_timeout", 32'(ep_of(w)), 32'(target));
        end
    endtask

    // Product must stay stable in IDLE after Done drops.
    task automatic hold_check(input int w, input logic [31:0] exp);
        repeat (3) @(posedge Clk);
        #1;
        check("hold_product", prod_of(w), exp);
        check("hold_done_low", 32'(done_of(w)), 32'd0);
        check("hold_busy_low", 32'(busy_of(w)), 32'd0);
    endtask

    typedef struct {
        logic        sm;
        logic [7:0]  s;
        logic [7:0]  m;
        logic [15:0] exp;
    } vec8_t;

    vec8_t vecs8[8] = '{
        '{1'b1, 8'h07, 8'hC5, 16'hFE63},   // 7 * -59 = -413
        '{1'b1, 8'h80, 8'h80, 16'h4000},   // -128 * -128
        '{1'b0, 8'hFF, 8'hFF, 16'hFE01},   // 255 * 255
        '{1'b0, 8'h80, 8'hFF, 16'h7F80},   // 128 * 255
        '{1'b1, 8'h80, 8'hFF, 16'h0080},   // -128 * -1
        '{1'b0, 8'h07, 8'hC5, 16'h0563},   // 7 * 197
        '{1'b1, 8'h7F, 8'h7F, 16'h3F01},   // 127 * 127
        '{1'b1, 8'h80, 8'h7F, 16'hC080}    // -128 * 127
    };

    initial begin
        int target8, target16, target2, base;
        int sa, sb, p;
        target8 = 0; target16 = 0; target2 = 0;

        // Reset state
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_prod8", 32'(prod8), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_x8", 32'(x8), 32'd0);
        check("rst_prod16", prod16, 32'd0);
        check("rst_prod2", 32'(prod2), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Directed WIDTH=8 vectors
        foreach (vecs8[i]) begin
            issue(8, vecs8[i].sm, 16'(vecs8[i].s), 16'(vecs8[i].m), 32'(vecs8[i].exp), 1'b1);
            check("w8_busy_after_start", 32'(busy8), 32'd1);
            target8++;
            wait_done(8, target8);
            hold_check(8, 32'(vecs8[i].exp));
        end

        // Start held high for 40 cycles: exactly one operation
        base = ep8;
        @(negedge Clk);
        sm8 = 1'b1; mc8 = 8'h07; mp8 = 8'hC5; st8 = 1'b1;
        @(posedge Clk);
        #1;
        q8.push_back(sb_t'{32'h0000FE63, cyc});
        repeat (39) @(posedge Clk);
        @(negedge Clk);
        check("held_start_done_still_high", 32'(done8), 32'd1);
        st8 = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        check("held_start_episodes", 32'(ep8 - base), 32'd1);
        check("held_start_product", 32'(prod8), 32'h0000FE63);
        check("held_start_done_low", 32'(done8), 32'd0);
        target8 = ep8;

        // Reset during the 5th SHIFT (sampled at edge k+10)
        issue(8, 1'b1, 16'h0007, 16'h00C5, 32'd0, 1'b0);
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        check("pre_reset_busy", 32'(busy8), 32'd1);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_prod", 32'(prod8), 32'd0);
        check("abort_x", 32'(x8), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        issue(8, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01, 1'b1);
        target8++;
        wait_done(8, target8);
        hold_check(8, 32'h0000FE01);

        // WIDTH=16
        issue(16, 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 1'b1);
        target16++;
        wait_done(16, target16);
        hold_check(16, 32'h00000001);
        issue(16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
        target16++;
        wait_done(16, target16);
        hold_check(16, 32'hFFFE0001);

        // WIDTH=2 exhaustive, both modes
        for (int mode = 0; mode < 2; mode++) begin
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    sa = (mode == 1 && a > 1) ? a - 4 : a;
                    sb = (mode == 1 && b > 1) ? b - 4 : b;
                    p  = (sa * sb) & 32'hF;
                    issue(2, 1'(mode), 16'(a), 16'(b), 32'(p), 1'b1);
                    target2++;
                    wait_done(2, target2);
                end
            end
        end
        repeat (3) @(posedge Clk);
        #1;
        check("w2_queue_empty", 32'(q2.size()), 32'd0);
        check("w8_queue_empty", 32'(q8.size()), 32'd0);
        check("w16_queue_empty", 32'(q16.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
